// File: rtl/fsm_fir.sv
// Control sequencer for a sample-by-sample FIR MAC datapath; Moore outputs decoded from the state register.
// START->MAC_LOOP in 3 edges; no backpressure, Petla_full/Licznik_full only steer the loop.
module fsm_fir (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       START,
   input  logic       Petla_full,
   input  logic       Licznik_full,
   output logic       pracuje,
   output logic       DONE,
   output logic [2:0] dbg_state,
   output logic       FSM_MUX_wyj,
   output logic       FSM_MUX_wej,
   output logic       FSM_MUX_CDC,
   output logic       FSM_zapisz_wsp,
   output logic       FSM_petla_en,
   output logic       FSM_reset_petla,
   output logic       FSM_zapisz_probki,
   output logic       FSM_reset_licznik,
   output logic       FSM_nowa_probka,
   output logic       FSM_nowa_shift,
   output logic       FSM_reset_shift,
   output logic       FSM_Acc_en,
   output logic       FSM_Acc_zapisz,
   output logic       FSM_reset_Acc
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      INIT        = 3'd1,
      FETCH       = 3'd2,
      MAC_LOOP    = 3'd3,
      NEXT_SAMPLE = 3'd4,
      DONE_STATE  = 3'd5
   } state_t;

   state_t state_q, state_d;

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:        state_d = START ? INIT : IDLE;
         INIT:        state_d = FETCH;
         FETCH:       state_d = MAC_LOOP;
         MAC_LOOP:    state_d = Petla_full ? NEXT_SAMPLE : MAC_LOOP;
         NEXT_SAMPLE: state_d = Licznik_full ? DONE_STATE : MAC_LOOP;
         DONE_STATE:  state_d = START ? DONE_STATE : IDLE;
         default:     state_d = IDLE; // codes 6/7 recover to IDLE
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign dbg_state = state_q;

   always_comb begin
      pracuje           = 1'b0;
      DONE              = 1'b0;
      FSM_MUX_wyj       = 1'b0;
      FSM_MUX_wej       = 1'b0;
      FSM_MUX_CDC       = 1'b0;
      FSM_zapisz_wsp    = 1'b0;
      FSM_petla_en      = 1'b0;
      FSM_reset_petla   = 1'b0;
      FSM_zapisz_probki = 1'b0;
      FSM_reset_licznik = 1'b0;
      FSM_nowa_probka   = 1'b0;
      FSM_nowa_shift    = 1'b0;
      FSM_reset_shift   = 1'b0;
      FSM_Acc_en        = 1'b0;
      FSM_Acc_zapisz    = 1'b0;
      FSM_reset_Acc     = 1'b0;
      // Every active-run state owns all three memory ports.
      if (state_q inside {INIT, FETCH, MAC_LOOP, NEXT_SAMPLE}) begin
         pracuje     = 1'b1;
         FSM_MUX_wyj = 1'b1;
         FSM_MUX_wej = 1'b1;
         FSM_MUX_CDC = 1'b1;
      end
      case (state_q)
         INIT: begin
            FSM_reset_petla   = 1'b1;
            FSM_reset_licznik = 1'b1;
            FSM_reset_shift   = 1'b1;
            FSM_reset_Acc     = 1'b1;
         end
         FETCH: begin
            FSM_nowa_probka = 1'b1;
            FSM_nowa_shift  = 1'b1;
         end
         MAC_LOOP: begin
            FSM_petla_en = 1'b1;
            FSM_Acc_en   = 1'b1;
         end
         NEXT_SAMPLE: begin
            FSM_Acc_zapisz    = 1'b1;
            FSM_zapisz_probki = 1'b1;
            FSM_reset_Acc     = 1'b1;
            FSM_reset_petla   = 1'b1;
            FSM_nowa_probka   = 1'b1;
            FSM_nowa_shift    = 1'b1;
         end
         DONE_STATE: DONE = 1'b1;
         default:    FSM_zapisz_wsp = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_fsm_fir.sv
// Directed bench for fsm_fir: table-driven reference model checked every cycle plus literal checkpoints.
module tb_fsm_fir;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       START = 1'b0;
   logic       Petla_full = 1'b0;
   logic       Licznik_full = 1'b0;
   logic       pracuje, DONE;
   logic [2:0] dbg_state;
   logic       FSM_MUX_wyj, FSM_MUX_wej, FSM_MUX_CDC, FSM_zapisz_wsp, FSM_petla_en;
   logic       FSM_reset_petla, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka;
   logic       FSM_nowa_shift, FSM_reset_shift, FSM_Acc_en, FSM_Acc_zapisz, FSM_reset_Acc;

   int errors = 0;
   int checks = 0;
   int m_state = 0;
   bit cmp_en = 1'b0;
   bit cnt_en = 1'b0;
   int probki_cnt = 0;
   int acc_cnt = 0;

   always #5 clk = ~clk;

   fsm_fir dut (
      .clk(clk), .rst_n(rst_n), .START(START), .Petla_full(Petla_full),
      .Licznik_full(Licznik_full), .pracuje(pracuje), .DONE(DONE), .dbg_state(dbg_state),
      .FSM_MUX_wyj(FSM_MUX_wyj), .FSM_MUX_wej(FSM_MUX_wej), .FSM_MUX_CDC(FSM_MUX_CDC),
      .FSM_zapisz_wsp(FSM_zapisz_wsp), .FSM_petla_en(FSM_petla_en),
      .FSM_reset_petla(FSM_reset_petla), .FSM_zapisz_probki(FSM_zapisz_probki),
      .FSM_reset_licznik(FSM_reset_licznik), .FSM_nowa_probka(FSM_nowa_probka),
      .FSM_nowa_shift(FSM_nowa_shift), .FSM_reset_shift(FSM_reset_shift),
      .FSM_Acc_en(FSM_Acc_en), .FSM_Acc_zapisz(FSM_Acc_zapisz), .FSM_reset_Acc(FSM_reset_Acc)
   );

   // Bit positions of the packed output word compared each cycle.
   localparam int PRAC = 15, DN = 14, MWY = 13, MWE = 12, MCDC = 11, WSP = 10, PEN = 9, RPET = 8;
   localparam int PROB = 7, RLIC = 6, NPR = 5, NSH = 4, RSH = 3, AEN = 2, AZAP = 1, RACC = 0;

   function automatic logic [15:0] bits(input int a, b = -1, c = -1, d = -1, e = -1, f = -1);
      logic [15:0] v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      if (d >= 0) v[d] = 1'b1;
      if (e >= 0) v[e] = 1'b1;
      if (f >= 0) v[f] = 1'b1;
      return v;
   endfunction

   function automatic logic [15:0] expected_out(input int s);
      logic [15:0] busy = bits(PRAC, MWY, MWE, MCDC);
      case (s)
         1:       return busy | bits(RPET, RLIC, RSH, RACC);
         2:       return busy | bits(NPR, NSH);
         3:       return busy | bits(PEN, AEN);
         4:       return busy | bits(AZAP, PROB, RACC, RPET, NPR, NSH);
         5:       return bits(DN);
         default: return bits(WSP);
      endcase
   endfunction

   function automatic int next_of(input int s, input logic st, input logic pf, input logic lf);
      case (s)
         0:       return st ? 1 : 0;
         1:       return 2;
         2:       return 3;
         3:       return pf ? 4 : 3;
         4:       return lf ? 5 : 3;
         5:       return st ? 5 : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_state <= 0;
      else        m_state <= next_of(m_state, START, Petla_full, Licznik_full);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   logic [15:0] act_out;
   assign act_out = {pracuje, DONE, FSM_MUX_wyj, FSM_MUX_wej, FSM_MUX_CDC, FSM_zapisz_wsp,
                     FSM_petla_en, FSM_reset_petla, FSM_zapisz_probki, FSM_reset_licznik,
                     FSM_nowa_probka, FSM_nowa_shift, FSM_reset_shift, FSM_Acc_en,
                     FSM_Acc_zapisz, FSM_reset_Acc};

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_state", int'(dbg_state), m_state);
         chk("model_outputs", int'(act_out), int'(expected_out(m_state)));
         chk("busy_done_excl", int'(pracuje & DONE), 0);
         if (cnt_en) begin
            probki_cnt += int'(FSM_zapisz_probki);
            acc_cnt    += int'(FSM_Acc_en);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_petla();
      Petla_full = 1'b1;
      step();
      Petla_full = 1'b0;
   endtask

   initial begin
      step(2);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      chk("reset_state", int'(dbg_state), 0);
      chk("reset_wsp", int'(FSM_zapisz_wsp), 1);
      step(10);
      chk("idle_10_state", int'(dbg_state), 0);
      chk("idle_10_busy", int'(pracuje), 0);
      chk("idle_10_done", int'(DONE), 0);
      chk("idle_10_wsp", int'(FSM_zapisz_wsp), 1);

      // Single sample run.
      START = 1'b1;
      step(); chk("start_init", int'(dbg_state), 1);
      step(); chk("start_fetch", int'(dbg_state), 2);
      step(); chk("start_mac", int'(dbg_state), 3);
      step(2); chk("mac_hold", int'(dbg_state), 3);
      pulse_petla();
      chk("next_state", int'(dbg_state), 4);
      chk("next_acc_zapisz", int'(FSM_Acc_zapisz), 1);
      Licznik_full = 1'b1;
      step();
      Licznik_full = 1'b0;
      chk("done_state", int'(dbg_state), 5);
      chk("done_flag", int'(DONE), 1);
      chk("done_not_busy", int'(pracuje), 0);
      step(5);
      chk("done_hold", int'(dbg_state), 5);
      START = 1'b0;
      step();
      chk("done_to_idle", int'(dbg_state), 0);

      // Four samples; START dropped once the run is under way.
      probki_cnt = 0;
      cnt_en = 1'b1;
      START = 1'b1;
      step(3);
      START = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(i + 1);
         pulse_petla();
         chk("multi_next", int'(dbg_state), 4);
         step();
         chk("multi_back_mac", int'(dbg_state), 3);
      end
      Petla_full = 1'b1;
      Licznik_full = 1'b1;
      step();
      Petla_full = 1'b0;
      chk("both_full_in_mac", int'(dbg_state), 4);
      step();
      Licznik_full = 1'b0;
      chk("multi_done", int'(dbg_state), 5);
      step();
      cnt_en = 1'b0;
      chk("multi_idle", int'(dbg_state), 0);
      chk("probki_pulses", probki_cnt, 4);

      // Long MAC_LOOP, then asynchronous reset between edges.
      START = 1'b1;
      step(3);
      START = 1'b0;
      acc_cnt = 0;
      cnt_en = 1'b1;
      step(20);
      cnt_en = 1'b0;
      chk("acc_en_20", acc_cnt, 20);
      chk("mac_before_rst", int'(dbg_state), 3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(dbg_state), 0);
      chk("async_rst_wsp", int'(FSM_zapisz_wsp), 1);
      chk("async_rst_acc", int'(FSM_Acc_en), 0);
      step();
      rst_n = 1'b1;
      step(4);
      chk("post_rst_wait", int'(dbg_state), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fsm_fir.md
FSM_FIR -- requirements
Module: fsm_fir

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 START  in  1  run request; level-sensitive.
REQ-004 Petla_full  in  1  MAC tap-loop counter reached last tap.
REQ-005 Licznik_full  in  1  sample counter reached last sample.
REQ-006 pracuje  out  1  busy flag.
REQ-007 DONE  out  1  processing finished.
REQ-008 dbg_state  out  3  current state code.
REQ-009 FSM_MUX_wyj  out  1  output-memory port select: 1 = FSM, 0 = CPU.
REQ-010 FSM_MUX_wej  out  1  input-memory port select: 1 = FSM, 0 = CPU.
REQ-011 FSM_MUX_CDC  out  1  CDC/bus select: 1 = FSM, 0 = CPU.
REQ-012 FSM_zapisz_wsp  out  1  coefficient memory write enable.
REQ-013 FSM_petla_en  out  1  tap-loop counter increment.
REQ-014 FSM_reset_petla  out  1  tap-loop counter clear.
REQ-015 FSM_zapisz_probki  out  1  output-sample memory write.
REQ-016 FSM_reset_licznik  out  1  sample counter clear.
REQ-017 FSM_nowa_probka  out  1  sample counter increment / fetch next input sample.
REQ-018 FSM_nowa_shift  out  1  shift new sample into delay line.
REQ-019 FSM_reset_shift  out  1  delay line clear.
REQ-020 FSM_Acc_en  out  1  accumulate product.
REQ-021 FSM_Acc_zapisz  out  1  latch accumulator into output register.
REQ-022 FSM_reset_Acc  out  1  accumulator clear.

Function
REQ-023 States and codes SHALL be: IDLE=0, INIT=1, FETCH=2, MAC_LOOP=3, NEXT_SAMPLE=4, DONE_STATE=5.
- dbg_state = state register.
REQ-024 Outputs SHALL be Moore, decoded combinationally from the state only; unlisted outputs are 0.
REQ-025 IDLE:
- FSM_zapisz_wsp=1; all MUX selects 0.
- START=1 -> INIT; else stay.
REQ-026 INIT:
- pracuje=1; MUX selects 1.
- FSM_reset_petla, FSM_reset_licznik, FSM_reset_shift, FSM_reset_Acc = 1.
- Unconditionally -> FETCH.
REQ-027 FETCH:
- pracuje=1; MUX selects 1.
- FSM_nowa_probka, FSM_nowa_shift = 1.
- Unconditionally -> MAC_LOOP.
REQ-028 MAC_LOOP:
- pracuje=1; MUX selects 1.
- FSM_petla_en, FSM_Acc_en = 1.
- Petla_full=1 -> NEXT_SAMPLE; else stay.
REQ-029 NEXT_SAMPLE (exactly one cycle):
- pracuje=1; MUX selects 1.
- FSM_Acc_zapisz, FSM_zapisz_probki, FSM_reset_Acc, FSM_reset_petla, FSM_nowa_probka, FSM_nowa_shift = 1.
- Licznik_full=1 -> DONE_STATE; else -> MAC_LOOP.
REQ-030 DONE_STATE:
- DONE=1, pracuje=0; MUX selects 0.
- Stay while START=1; START=0 -> IDLE.
REQ-031 START SHALL be ignored in INIT, FETCH, MAC_LOOP and NEXT_SAMPLE; deasserting START mid-run does not abort.
REQ-032 Petla_full and Licznik_full SHALL be evaluated only in MAC_LOOP and NEXT_SAMPLE respectively; both asserted in MAC_LOOP -> NEXT_SAMPLE only.
REQ-033 Minimum latency START -> MAC_LOOP SHALL be 3 rising edges (IDLE->INIT->FETCH->MAC_LOOP).
REQ-034 Illegal codes 6 and 7 SHALL decode outputs as IDLE and go to IDLE on the next edge.
REQ-035 pracuje and DONE SHALL never both be 1.

Reset
REQ-036 rst_n=0 SHALL force IDLE immediately, independent of clk.
- Outputs: dbg_state=0, FSM_zapisz_wsp=1, all others 0.
REQ-037 Reset asserted in any state, including mid MAC_LOOP, SHALL abort to IDLE; after release the block waits for START.

Verification
REQ-038 Reset then START=0 for 10 cycles -> dbg_state stays 0, pracuje=0, DONE=0, FSM_zapisz_wsp=1.
REQ-039 Single sample:
- START=1 -> dbg_state 1,2,3 on successive edges.
- Petla_full pulsed 1 cycle in state 3 -> state 4 with FSM_Acc_zapisz=1.
- Licznik_full=1 in state 4 -> state 5, DONE=1, pracuje=0.
REQ-040 Multiple samples: Licznik_full=0 in state 4 -> back to state 3; repeat 3 times, then Licznik_full=1 -> state 5; FSM_zapisz_probki pulses exactly 3+1 times.
REQ-041 DONE hold: START held 1 in state 5 for 5 cycles -> stays 5; START=0 -> state 0 next edge.
REQ-042 rst_n=0 asynchronously mid state 3 -> dbg_state=0 before next clk edge; MAC_LOOP held with Petla_full=0 for 20 cycles beforehand keeps FSM_Acc_en=1 throughout.
REQ-043 START dropped to 0 in state 3 -> run continues to state 5 normally.
